// File: rtl/adc_scan_seq.sv
// Channel-scan sequencer: walks ADC channels 0..N-1 with a req/ack handshake per
// channel and writes each sample into the ADC_RAW register file.
module adc_scan_seq #(
  parameter int unsigned NCH_MAX = 8,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned PER_W   = 24,
  localparam int unsigned CH_W   = (NCH_MAX > 1) ? $clog2(NCH_MAX) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cfg_enable,
  input  logic              cfg_start,
  input  logic              cfg_snapshot,
  input  logic              cfg_continuous,
  input  logic [3:0]        cfg_num_ch,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [TMO_W-1:0]  cfg_timeout,
  output logic              adc_req_o,
  output logic [CH_W-1:0]   adc_ch_o,
  input  logic              adc_ack_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic              raw_we_o,
  output logic [CH_W-1:0]   raw_ch_o,
  output logic [31:0]       raw_data_o,
  output logic              busy_o,
  output logic              scan_done_o,
  output logic              tmo_o,
  output logic [CH_W-1:0]   tmo_ch_o,
  output logic [31:0]       scan_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_WAIT = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic             pend_q, pend_d;

  logic             req_d, busy_d, raw_we_d, done_d, tmo_d;
  logic [CH_W-1:0]  raw_ch_d, tmo_ch_d;
  logic [31:0]      raw_data_d, scan_cnt_d;

  logic             trig;
  logic             ack_hit;
  logic             tmo_hit;
  logic             last_ch;
  logic             scan_start;
  logic [CH_W-1:0]  num_last;

  assign trig    = cfg_enable && (cfg_start || cfg_snapshot);
  assign ack_hit = (state_q == S_REQ) && adc_ack_i;
  assign tmo_hit = (state_q == S_REQ) && !adc_ack_i && (cfg_timeout != '0) &&
                   (TMO_W'(tmo_cnt_q + TMO_W'(1)) == cfg_timeout);
  assign last_ch = (ch_q == last_q);

  // Index of the last channel of a scan: 0 means one channel, large values clamp.
  always_comb begin
    num_last = '0;
    if (cfg_num_ch == 4'd0) begin
      num_last = '0;
    end else if (32'(cfg_num_ch) > NCH_MAX) begin
      num_last = CH_W'(NCH_MAX - 1);
    end else begin
      num_last = CH_W'(cfg_num_ch - 4'd1);
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped enable aborts from any state.
  always_comb begin
    state_d = state_q;
    if (!cfg_enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (trig) state_d = S_REQ;
        end
        S_REQ: begin
          if (ack_hit || tmo_hit) state_d = S_WR;
        end
        S_WR: begin
          state_d = last_ch ? S_DONE : S_REQ;
        end
        S_DONE: begin
          if (pend_q || trig) begin
            state_d = S_REQ;
          end else if (cfg_continuous) begin
            state_d = (cfg_period == '0) ? S_REQ : S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (trig) begin
            state_d = S_REQ;
          end else if (!cfg_continuous) begin
            state_d = S_IDLE;
          end else if (per_cnt_q == '0) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign scan_start = (state_d == S_REQ) && (state_q != S_REQ) && (state_q != S_WR);

  // Output and datapath next values; outputs are registered from the next state.
  always_comb begin
    ch_d       = ch_q;
    last_d     = last_q;
    tmo_cnt_d  = tmo_cnt_q;
    per_cnt_d  = per_cnt_q;
    pend_d     = pend_q;
    raw_ch_d   = raw_ch_o;
    raw_data_d = raw_data_o;
    tmo_ch_d   = tmo_ch_o;
    scan_cnt_d = scan_cnt_o;
    raw_we_d   = 1'b0;
    tmo_d      = 1'b0;
    req_d      = (state_d == S_REQ);
    busy_d     = (state_d == S_REQ) || (state_d == S_WR) || (state_d == S_DONE);
    done_d     = (state_d == S_DONE);

    if (scan_start) begin
      ch_d   = '0;
      last_d = num_last;
    end else if ((state_q == S_WR) && (state_d == S_REQ)) begin
      ch_d = ch_q + CH_W'(1);
    end

    if ((state_d == S_REQ) && (state_q != S_REQ)) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_REQ) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end

    if ((state_q == S_DONE) && (state_d == S_WAIT)) begin
      per_cnt_d = cfg_period - PER_W'(1);
    end else if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
      per_cnt_d = per_cnt_q - PER_W'(1);
    end

    // One-deep pending trigger; coalesces repeats, dropped on abort or scan start.
    if (!cfg_enable || scan_start) begin
      pend_d = 1'b0;
    end else if (trig && ((state_q == S_REQ) || (state_q == S_WR) || (state_q == S_DONE))) begin
      pend_d = 1'b1;
    end

    if ((state_q == S_REQ) && (state_d == S_WR)) begin
      if (tmo_hit) begin
        tmo_d    = 1'b1;
        tmo_ch_d = ch_q;
      end else begin
        raw_we_d   = 1'b1;
        raw_ch_d   = ch_q;
        raw_data_d = 32'(adc_data_i);
      end
    end

    if (state_d == S_DONE) begin
      scan_cnt_d = scan_cnt_o + 32'd1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ch_q        <= '0;
      last_q      <= '0;
      tmo_cnt_q   <= '0;
      per_cnt_q   <= '0;
      pend_q      <= 1'b0;
      adc_req_o   <= 1'b0;
      busy_o      <= 1'b0;
      raw_we_o    <= 1'b0;
      raw_ch_o    <= '0;
      raw_data_o  <= '0;
      scan_done_o <= 1'b0;
      tmo_o       <= 1'b0;
      tmo_ch_o    <= '0;
      scan_cnt_o  <= '0;
    end else begin
      ch_q        <= ch_d;
      last_q      <= last_d;
      tmo_cnt_q   <= tmo_cnt_d;
      per_cnt_q   <= per_cnt_d;
      pend_q      <= pend_d;
      adc_req_o   <= req_d;
      busy_o      <= busy_d;
      raw_we_o    <= raw_we_d;
      raw_ch_o    <= raw_ch_d;
      raw_data_o  <= raw_data_d;
      scan_done_o <= done_d;
      tmo_o       <= tmo_d;
      tmo_ch_o    <= tmo_ch_d;
      scan_cnt_o  <= scan_cnt_d;
    end
  end

  assign adc_ch_o = ch_q;

endmodule

// File: tb/tb_adc_scan_seq.sv
// Scoreboard bench for adc_scan_seq: an ADC model pushes expected writes on each
// ack, and a monitor pops and compares them against raw_we_o.
module tb_adc_scan_seq;
  localparam int unsigned NCH_MAX = 8;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned TMO_W   = 16;
  localparam int unsigned PER_W   = 24;
  localparam int unsigned CH_W    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_enable = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_snapshot = 1'b0;
  logic              cfg_continuous = 1'b0;
  logic [3:0]        cfg_num_ch = 4'd0;
  logic [PER_W-1:0]  cfg_period = '0;
  logic [TMO_W-1:0]  cfg_timeout = '0;
  logic              adc_req_o;
  logic [CH_W-1:0]   adc_ch_o;
  logic              adc_ack_i = 1'b0;
  logic [DATA_W-1:0] adc_data_i = '0;
  logic              raw_we_o;
  logic [CH_W-1:0]   raw_ch_o;
  logic [31:0]       raw_data_o;
  logic              busy_o;
  logic              scan_done_o;
  logic              tmo_o;
  logic [CH_W-1:0]   tmo_ch_o;
  logic [31:0]       scan_cnt_o;

  int checks = 0;
  int failures = 0;

  // ADC model and monitor state
  int ack_lat = 1;
  int dead_ch = -1;
  int lat_cnt = 0;
  int cyc = 0;
  logic ack_at_edge = 1'b0;
  logic [CH_W-1:0] exp_ch[$];
  logic [31:0]     exp_data[$];
  int done_cyc[$];
  int n_we = 0, n_done = 0, n_tmo = 0, n_req = 0, n_overlap = 0, n_dead_req = 0;
  logic [31:0] exp_scan = 32'd0;

  adc_scan_seq #(
    .NCH_MAX(NCH_MAX), .DATA_W(DATA_W), .TMO_W(TMO_W), .PER_W(PER_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .cfg_enable(cfg_enable),
    .cfg_start(cfg_start),
    .cfg_snapshot(cfg_snapshot),
    .cfg_continuous(cfg_continuous),
    .cfg_num_ch(cfg_num_ch),
    .cfg_period(cfg_period),
    .cfg_timeout(cfg_timeout),
    .adc_req_o(adc_req_o),
    .adc_ch_o(adc_ch_o),
    .adc_ack_i(adc_ack_i),
    .adc_data_i(adc_data_i),
    .raw_we_o(raw_we_o),
    .raw_ch_o(raw_ch_o),
    .raw_data_o(raw_data_o),
    .busy_o(busy_o),
    .scan_done_o(scan_done_o),
    .tmo_o(tmo_o),
    .tmo_ch_o(tmo_ch_o),
    .scan_cnt_o(scan_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ack_at_edge <= adc_ack_i;
  end

  // ADC front-end model: acks after ack_lat request cycles, never on dead_ch.
  always @(negedge clk) begin
    if (!rst_n) begin
      adc_ack_i = 1'b0;
      lat_cnt = 0;
    end else if (adc_req_o && (int'(adc_ch_o) != dead_ch)) begin
      lat_cnt++;
      if (lat_cnt == ack_lat) begin
        adc_ack_i = 1'b1;
        adc_data_i = 24'h001000 + 24'(adc_ch_o);
        exp_ch.push_back(adc_ch_o);
        exp_data.push_back(32'h00001000 + 32'(adc_ch_o));
      end else begin
        adc_ack_i = 1'b0;
      end
    end else begin
      adc_ack_i = 1'b0;
      lat_cnt = 0;
    end
  end

  // Output monitor: scoreboard pop on every write, event counters otherwise.
  always @(negedge clk) begin
    logic [CH_W-1:0] ech;
    logic [31:0]     edat;
    if (rst_n) begin
      if (adc_req_o && raw_we_o) n_overlap++;
      if (adc_req_o) n_req++;
      if (adc_req_o && (dead_ch >= 0) && (int'(adc_ch_o) == dead_ch)) n_dead_req++;
      if (scan_done_o) begin
        n_done++;
        done_cyc.push_back(cyc);
      end
      if (tmo_o) n_tmo++;
      if (raw_we_o) begin
        n_we++;
        checks++;
        if (ack_at_edge !== 1'b1) begin
          failures++;
          $display("FAIL wr_latency: ack at previous edge got %0b want 1", ack_at_edge);
        end
        checks++;
        if (exp_ch.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_write: ch=%0d data=%h, expected no write", raw_ch_o, raw_data_o);
        end else begin
          ech  = exp_ch.pop_front();
          edat = exp_data.pop_front();
          if ((raw_ch_o !== ech) || (raw_data_o !== edat)) begin
            failures++;
            $display("FAIL sb_write: got ch=%0d data=%h want ch=%0d data=%h",
                     raw_ch_o, raw_data_o, ech, edat);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_snap();
    @(negedge clk);
    cfg_snapshot = 1'b1;
    @(negedge clk);
    cfg_snapshot = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({adc_req_o, busy_o, raw_we_o, scan_done_o, tmo_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 00000",
               {adc_req_o, busy_o, raw_we_o, scan_done_o, tmo_o});
    end
    checks++;
    if ({adc_ch_o, raw_ch_o, tmo_ch_o, raw_data_o, scan_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_values: ch=%0d rch=%0d tch=%0d data=%h cnt=%0d want all 0",
               adc_ch_o, raw_ch_o, tmo_ch_o, raw_data_o, scan_cnt_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int we0, d0;
    we0 = n_we; d0 = n_done;
    cfg_enable = 1'b1; cfg_num_ch = 4'd4; ack_lat = 3;
    pulse_start();
    checks++;
    if ({busy_o, adc_req_o, adc_ch_o} !== {1'b1, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL trig_latency: busy=%0b req=%0b ch=%0d want 1 1 0", busy_o, adc_req_o, adc_ch_o);
    end
    wait_done(d0 + 1, 100, ok);
    exp_scan += 32'd1;
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout: scan_done_o got none want 1"); end
    repeat (5) @(negedge clk);
    checks++;
    if (n_we - we0 != 4) begin failures++; $display("FAIL basic_writes: got %0d want 4", n_we - we0); end
    checks++;
    if (n_done - d0 != 1) begin failures++; $display("FAIL basic_done: got %0d want 1", n_done - d0); end
    checks++;
    if (scan_cnt_o !== exp_scan) begin failures++; $display("FAIL basic_cnt: got %0d want %0d", scan_cnt_o, exp_scan); end
    checks++;
    if (n_overlap != 0) begin failures++; $display("FAIL req_we_overlap: got %0d want 0", n_overlap); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: got %0b want 0", busy_o); end
  endtask

  task automatic test_num_ch();
    bit ok;
    int we0;
    ack_lat = 1;
    cfg_num_ch = 4'd0;
    we0 = n_we;
    pulse_start();
    wait_done(n_done + 1, 100, ok);
    exp_scan += 32'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || (n_we - we0 != 1)) begin
      failures++;
      $display("FAIL numch0_writes: got %0d (done=%0b) want 1", n_we - we0, ok);
    end
    cfg_num_ch = 4'd12;
    we0 = n_we;
    pulse_start();
    wait_done(n_done + 1, 100, ok);
    exp_scan += 32'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || (n_we - we0 != 8)) begin
      failures++;
      $display("FAIL numch12_writes: got %0d (done=%0b) want 8", n_we - we0, ok);
    end
    checks++;
    if (scan_cnt_o !== exp_scan) begin failures++; $display("FAIL numch_cnt: got %0d want %0d", scan_cnt_o, exp_scan); end
  endtask

  task automatic test_timeout();
    bit ok;
    int we0, t0, d0;
    we0 = n_we; t0 = n_tmo; d0 = n_done;
    cfg_num_ch = 4'd4; cfg_timeout = 16'd5; ack_lat = 1; dead_ch = 2; n_dead_req = 0;
    pulse_start();
    wait_done(d0 + 1, 100, ok);
    exp_scan += 32'd1;
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin failures++; $display("FAIL tmo_scan_done: got none want 1"); end
    checks++;
    if (n_tmo - t0 != 1) begin failures++; $display("FAIL tmo_pulses: got %0d want 1", n_tmo - t0); end
    checks++;
    if (tmo_ch_o !== 3'd2) begin failures++; $display("FAIL tmo_ch: got %0d want 2", tmo_ch_o); end
    checks++;
    if (n_we - we0 != 3) begin failures++; $display("FAIL tmo_writes: got %0d want 3", n_we - we0); end
    checks++;
    if (n_dead_req != 5) begin failures++; $display("FAIL tmo_req_cycles: got %0d want 5", n_dead_req); end
    dead_ch = -1; cfg_timeout = '0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int we0, d0;
    we0 = n_we; d0 = n_done;
    cfg_num_ch = 4'd4; ack_lat = 3;
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_snap();
    repeat (2) @(negedge clk);
    pulse_snap();
    repeat (2) @(negedge clk);
    pulse_snap();
    wait_done(d0 + 2, 200, ok);
    exp_scan += 32'd2;
    repeat (50) @(negedge clk);
    checks++;
    if (!ok || (n_done - d0 != 2)) begin
      failures++;
      $display("FAIL b2b_scans: got %0d want 2", n_done - d0);
    end
    checks++;
    if (n_we - we0 != 8) begin failures++; $display("FAIL b2b_writes: got %0d want 8", n_we - we0); end
    checks++;
    if (scan_cnt_o !== exp_scan) begin failures++; $display("FAIL b2b_cnt: got %0d want %0d", scan_cnt_o, exp_scan); end
  endtask

  task automatic test_continuous();
    bit ok;
    int d0, r0, sz;
    d0 = n_done;
    cfg_num_ch = 4'd2; ack_lat = 1; cfg_period = 24'd10; cfg_continuous = 1'b1;
    pulse_start();
    wait_done(d0 + 3, 300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL cont_timeout: done got %0d want 3", n_done - d0); end
    sz = done_cyc.size();
    checks++;
    if ((sz < 3) || (done_cyc[sz-1] - done_cyc[sz-2] != 15)) begin
      failures++;
      $display("FAIL cont_spacing_b: got %0d want 15", (sz < 3) ? -1 : done_cyc[sz-1] - done_cyc[sz-2]);
    end
    checks++;
    if ((sz < 3) || (done_cyc[sz-2] - done_cyc[sz-3] != 15)) begin
      failures++;
      $display("FAIL cont_spacing_a: got %0d want 15", (sz < 3) ? -1 : done_cyc[sz-2] - done_cyc[sz-3]);
    end
    repeat (3) @(negedge clk);
    cfg_continuous = 1'b0;
    r0 = n_req;
    repeat (40) @(negedge clk);
    exp_scan += 32'd3;
    checks++;
    if (n_req != r0) begin failures++; $display("FAIL cont_stop_req: got %0d req cycles want 0", n_req - r0); end
    checks++;
    if (n_done - d0 != 3) begin failures++; $display("FAIL cont_stop_done: got %0d want 3", n_done - d0); end
    checks++;
    if (scan_cnt_o !== exp_scan) begin failures++; $display("FAIL cont_cnt: got %0d want %0d", scan_cnt_o, exp_scan); end
  endtask

  task automatic test_abort();
    bit ok;
    int we0, d0;
    we0 = n_we; d0 = n_done;
    cfg_num_ch = 4'd4; ack_lat = 2; dead_ch = 1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_req_o && (adc_ch_o == 3'd1)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_no_ch1_req: got none want req on ch1"); end
    repeat (2) @(negedge clk);
    cfg_enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({adc_req_o, busy_o} !== 2'b00) begin
      failures++;
      $display("FAIL abort_req_drop: req=%0b busy=%0b want 0 0", adc_req_o, busy_o);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (n_done != d0) begin failures++; $display("FAIL abort_done: got %0d want 0", n_done - d0); end
    checks++;
    if (scan_cnt_o !== exp_scan) begin failures++; $display("FAIL abort_cnt: got %0d want %0d", scan_cnt_o, exp_scan); end
    checks++;
    if ((n_we - we0 != 1) || (exp_ch.size() != 0)) begin
      failures++;
      $display("FAIL abort_writes: got %0d pending=%0d want 1 0", n_we - we0, exp_ch.size());
    end
    dead_ch = -1;
    cfg_enable = 1'b1;
  endtask

  task automatic test_reset_mid_scan();
    cfg_num_ch = 4'd4; ack_lat = 3;
    pulse_start();
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({adc_req_o, busy_o, raw_we_o, scan_done_o, tmo_o} !== 5'b0) begin
      failures++;
      $display("FAIL rst_strobes: got %b want 00000", {adc_req_o, busy_o, raw_we_o, scan_done_o, tmo_o});
    end
    checks++;
    if (adc_ch_o !== 3'd0) begin failures++; $display("FAIL rst_adc_ch: got %0d want 0", adc_ch_o); end
    checks++;
    if (raw_data_o !== 32'd0) begin failures++; $display("FAIL rst_raw_data: got %h want 0", raw_data_o); end
    checks++;
    if (tmo_ch_o !== 3'd0) begin failures++; $display("FAIL rst_tmo_ch: got %0d want 0", tmo_ch_o); end
    checks++;
    if (scan_cnt_o !== 32'd0) begin failures++; $display("FAIL rst_scan_cnt: got %0d want 0", scan_cnt_o); end
    exp_ch.delete();
    exp_data.delete();
    exp_scan = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, scan_cnt_o} !== {1'b0, exp_scan}) begin
      failures++;
      $display("FAIL rst_after: busy=%0b cnt=%0d want 0 0", busy_o, scan_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_num_ch();
    test_timeout();
    test_back_to_back();
    test_continuous();
    test_abort();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
